// File: rtl/trace_dma_pkg.sv
// Shared types and constants for the trace DMA writer.
// Beat geometry, AXI encodings and the burst FSM state type.
package trace_dma_pkg;

    localparam int BEAT_W = 512;
    localparam int KEEP_W = 64;

    localparam logic [2:0] AXSIZE_64B = 3'b110;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_e;

endpackage

// File: rtl/trace_beat_fifo.sv
// First-word-fall-through beat FIFO with registered count/full/empty.
// Synchronous flush discards all stored beats.
module trace_beat_fifo
    import trace_dma_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [BEAT_W-1:0]        din,
    input  logic                     pop,
    output logic [BEAT_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BEAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              do_push;
    logic              do_pop;
    logic [CW-1:0]     count_nxt;

    // A full FIFO only takes a beat when the head leaves the same cycle.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    assign head = mem[rp];

    // Beat storage; no reset needed for the data array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/axi_trace_dma_writer.sv
// Writes buffered trace beats into a host ring as aligned AXI4 INCR bursts.
// Lossless: s_ready drops while the beat FIFO is full.
module axi_trace_dma_writer
    import trace_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BEAT_W-1:0]     s_data,
    input  logic [KEEP_W-1:0]     s_keep,
    input  logic                  s_last,
    input  logic                  cfg_enable,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [31:0]           cfg_size,
    input  logic [31:0]           cfg_rd_ptr,
    output logic [31:0]           sts_wr_ptr,
    output logic                  sts_err,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [BEAT_W-1:0]     m_wdata,
    output logic [KEEP_W-1:0]     m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e             state;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [BEAT_W-1:0]     fifo_head;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  flush_pend;
    logic                  en_q;
    logic [8:0]            len_q;
    logic [8:0]            beat_q;
    logic [31:0]           count32;
    logic [31:0]           align;
    logic [31:0]           len;
    logic [31:0]           free;
    logic                  go;
    logic [ADDR_WIDTH-1:0] awaddr_nxt;

    assign s_ready   = !cfg_enable || !fifo_full;
    assign push      = s_valid && s_ready && cfg_enable && (s_keep != '0);
    assign pop       = m_wvalid && m_wready;
    assign flush     = (state == ST_IDLE) && !cfg_enable;
    assign m_wdata   = fifo_head;
    assign m_wstrb   = '1;
    assign m_awsize  = AXSIZE_64B;
    assign m_awburst = BURST_INCR;

    // Burst sizing: never past the next BURST_LEN boundary, never past free space.
    always_comb begin
        count32    = 32'(fifo_count);
        align      = 32'(BURST_LEN) - (sts_wr_ptr & 32'(BURST_LEN - 1));
        len        = (count32 < align) ? count32 : align;
        free       = cfg_size - (sts_wr_ptr - cfg_rd_ptr);
        go         = cfg_enable && (len != '0) && (free >= len) &&
                     ((count32 >= align) || flush_pend);
        awaddr_nxt = cfg_base +
                     (ADDR_WIDTH'(sts_wr_ptr & (cfg_size - 1'b1)) << 6);
    end

    trace_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Flush request lives until the FIFO has drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (push && s_last) begin
            flush_pend <= 1'b1;
        end else if (fifo_empty) begin
            flush_pend <= 1'b0;
        end
    end

    // Burst FSM with registered AXI outputs and the committed ring pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            m_awvalid  <= 1'b0;
            m_awaddr   <= '0;
            m_awlen    <= '0;
            m_wvalid   <= 1'b0;
            m_wlast    <= 1'b0;
            m_bready   <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            sts_wr_ptr <= '0;
            sts_err    <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            en_q <= cfg_enable;
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        len_q     <= len[8:0];
                        m_awaddr  <= awaddr_nxt;
                        m_awlen   <= 8'(len - 1);
                        m_awvalid <= 1'b1;
                        state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        m_wvalid  <= 1'b1;
                        m_wlast   <= (len_q == 9'd1);
                        beat_q    <= '0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_wready) begin
                        if (m_wlast) begin
                            m_wvalid <= 1'b0;
                            m_wlast  <= 1'b0;
                            m_bready <= 1'b1;
                            state    <= ST_B;
                        end else begin
                            beat_q  <= beat_q + 9'd1;
                            m_wlast <= ((beat_q + 9'd2) == len_q);
                        end
                    end
                end
                ST_B: begin
                    if (m_bvalid) begin
                        m_bready   <= 1'b0;
                        sts_wr_ptr <= sts_wr_ptr + 32'(len_q);
                        if (m_bresp != RESP_OKAY) begin
                            sts_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (cfg_enable && !en_q) begin
                sts_wr_ptr <= '0;
                sts_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_trace_dma_writer.sv
// Directed bench for axi_trace_dma_writer.
// Source and AXI slave act on the falling edge; checks run after rising edges.
module tb_axi_trace_dma_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] s_data;
    logic [63:0]  s_keep;
    logic         s_last;
    logic         cfg_enable;
    logic [63:0]  cfg_base;
    logic [31:0]  cfg_size;
    logic [31:0]  cfg_rd_ptr;
    logic [31:0]  sts_wr_ptr;
    logic         sts_err;
    logic         m_awvalid;
    logic         m_awready;
    logic [63:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic [1:0]   m_awburst;
    logic         m_wvalid;
    logic         m_wready;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wlast;
    logic         m_bvalid;
    logic         m_bready;
    logic [1:0]   m_bresp;

    int errors = 0;
    int checks = 0;

    int to_send = 0;
    int seq = 0;
    int exp_w = 0;
    int aw_n = 0;
    int w_n = 0;
    int b_n = 0;
    int wb = 0;
    int w0 = 0;
    bit last_req = 1'b0;
    bit b_pend = 1'b0;
    bit b_clr = 1'b0;
    logic [1:0]  resp_next = 2'b00;
    logic [63:0] last_addr = '0;
    logic [7:0]  last_len = '0;

    axi_trace_dma_writer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_keep     (s_keep),
        .s_last     (s_last),
        .cfg_enable (cfg_enable),
        .cfg_base   (cfg_base),
        .cfg_size   (cfg_size),
        .cfg_rd_ptr (cfg_rd_ptr),
        .sts_wr_ptr (sts_wr_ptr),
        .sts_err    (sts_err),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_awaddr   (m_awaddr),
        .m_awlen    (m_awlen),
        .m_awsize   (m_awsize),
        .m_awburst  (m_awburst),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_wlast    (m_wlast),
        .m_bvalid   (m_bvalid),
        .m_bready   (m_bready),
        .m_bresp    (m_bresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int n, input bit l);
        last_req = l;
        to_send  = n;
    endtask

    task automatic wait_b(input int target);
        int k = 0;
        while (b_n < target && k < 600) begin
            tick(1);
            k++;
        end
        chk("b_done", 64'(b_n >= target), 64'd1);
        tick(2);
    endtask

    task automatic wait_send();
        int k = 0;
        while (to_send > 0 && k < 600) begin
            tick(1);
            k++;
        end
        chk("send_done", 64'(to_send), 64'd0);
    endtask

    task automatic wait_wv();
        int k = 0;
        while (!m_wvalid && k < 200) begin
            tick(1);
            k++;
        end
        chk("wvalid_seen", 64'(m_wvalid), 64'd1);
    endtask

    task automatic re_enable();
        cfg_enable = 1'b0;
        tick(2);
        exp_w      = seq;
        cfg_enable = 1'b1;
        tick(1);
    endtask

    // Falling-edge source and AXI slave; handshakes fire at the next rise.
    initial begin
        forever begin
            @(negedge clk);
            s_valid = (to_send > 0);
            s_data  = {480'd0, 32'(seq)};
            s_last  = last_req && (to_send == 1);
            if (b_clr) begin
                m_bvalid = 1'b0;
                m_bresp  = 2'b00;
                b_clr    = 1'b0;
            end
            if (b_pend) begin
                m_bvalid = 1'b1;
                m_bresp  = resp_next;
                b_pend   = 1'b0;
            end
            if (s_valid && s_ready) begin
                seq++;
                to_send--;
            end
            if (m_awvalid && m_awready) begin
                aw_n++;
                last_addr = m_awaddr;
                last_len  = m_awlen;
            end
            if (m_wvalid && m_wready) begin
                w_n++;
                chk("wdata", 64'(m_wdata[31:0]), 64'(exp_w));
                chk("wlast", 64'(m_wlast), 64'(wb == int'(last_len)));
                exp_w++;
                if (m_wlast) begin
                    b_pend = 1'b1;
                    wb     = 0;
                end else begin
                    wb++;
                end
            end
            if (m_bvalid && m_bready) begin
                b_clr = 1'b1;
                b_n++;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_keep     = '1;
        s_last     = 1'b0;
        cfg_enable = 1'b0;
        cfg_base   = 64'h1000;
        cfg_size   = 32'd64;
        cfg_rd_ptr = 32'd0;
        m_awready  = 1'b1;
        m_wready   = 1'b1;
        m_bvalid   = 1'b0;
        m_bresp    = 2'b00;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_wr_ptr", 64'(sts_wr_ptr), 64'd0);
        chk("rst_err", 64'(sts_err), 64'd0);
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_bready", 64'(m_bready), 64'd0);

        // One full aligned burst
        cfg_enable = 1'b1;
        tick(1);
        send(16, 1'b0);
        wait_b(1);
        chk("s1_awaddr", last_addr, 64'h1000);
        chk("s1_awlen", 64'(last_len), 64'd15);
        chk("s1_awsize", 64'(m_awsize), 64'd6);
        chk("s1_awburst", 64'(m_awburst), 64'd1);
        chk("s1_wstrb", m_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("s1_wbeats", 64'(w_n), 64'd16);
        chk("s1_wr_ptr", 64'(sts_wr_ptr), 64'd16);

        // Flush of a short packet, then realignment
        re_enable();
        chk("s2_ptr_clr", 64'(sts_wr_ptr), 64'd0);
        send(5, 1'b1);
        wait_b(2);
        chk("s2a_awaddr", last_addr, 64'h1000);
        chk("s2a_awlen", 64'(last_len), 64'd4);
        chk("s2a_wr_ptr", 64'(sts_wr_ptr), 64'd5);
        send(16, 1'b0);
        wait_b(3);
        chk("s2b_awaddr", last_addr, 64'h1140);
        chk("s2b_awlen", 64'(last_len), 64'd10);
        chk("s2b_wr_ptr", 64'(sts_wr_ptr), 64'd16);
        tick(30);
        chk("s2_remainder", 64'(aw_n), 64'd3);

        // Ring full stall and wrap
        cfg_enable = 1'b0;
        tick(2);
        cfg_size   = 32'd32;
        exp_w      = seq;
        cfg_enable = 1'b1;
        tick(1);
        send(80, 1'b0);
        wait_b(5);
        tick(100);
        chk("s3_ready_low", 64'(s_ready), 64'd0);
        chk("s3_aw_cnt", 64'(aw_n), 64'd5);
        chk("s3_awaddr2", last_addr, 64'h1400);
        chk("s3_wr_ptr", 64'(sts_wr_ptr), 64'd32);
        cfg_rd_ptr = 32'd16;
        wait_b(6);
        chk("s3_wrap_addr", last_addr, 64'h1000);
        chk("s3_wrap_ptr", 64'(sts_wr_ptr), 64'd48);
        tick(50);
        chk("s3_stall2", 64'(aw_n), 64'd6);
        cfg_enable = 1'b0;
        to_send    = 0;
        tick(3);
        chk("s3_ready_dis", 64'(s_ready), 64'd1);
        cfg_size   = 32'd64;
        cfg_rd_ptr = 32'd0;
        exp_w      = seq;

        // Error response is sticky
        cfg_enable = 1'b1;
        tick(1);
        chk("s4_ptr_clr", 64'(sts_wr_ptr), 64'd0);
        resp_next = 2'b10;
        send(16, 1'b0);
        wait_b(7);
        chk("s4_err", 64'(sts_err), 64'd1);
        chk("s4_wr_ptr", 64'(sts_wr_ptr), 64'd16);
        resp_next = 2'b00;
        send(16, 1'b0);
        wait_b(8);
        chk("s4_err_stuck", 64'(sts_err), 64'd1);
        chk("s4_awaddr", last_addr, 64'h1400);
        chk("s4_wr_ptr2", 64'(sts_wr_ptr), 64'd32);

        // Disable during W with 20 beats queued
        w0       = w_n;
        m_wready = 1'b0;
        send(20, 1'b0);
        wait_send();
        tick(3);
        chk("s5_aw_cnt", 64'(aw_n), 64'd9);
        cfg_enable = 1'b0;
        tick(2);
        m_wready = 1'b1;
        wait_b(9);
        tick(3);
        chk("s5_awaddr", last_addr, 64'h1800);
        chk("s5_beats", 64'(w_n - w0), 64'd16);
        chk("s5_wr_ptr", 64'(sts_wr_ptr), 64'd48);
        chk("s5_err_hold", 64'(sts_err), 64'd1);
        chk("s5_ready", 64'(s_ready), 64'd1);
        tick(20);
        chk("s5_no_burst", 64'(aw_n), 64'd9);
        exp_w      = seq;
        cfg_enable = 1'b1;
        tick(1);
        chk("s5_ptr_clr", 64'(sts_wr_ptr), 64'd0);
        chk("s5_err_clr", 64'(sts_err), 64'd0);
        send(16, 1'b0);
        wait_b(10);
        chk("s5_awaddr2", last_addr, 64'h1000);
        chk("s5_wr_ptr2", 64'(sts_wr_ptr), 64'd16);

        // Reset in the middle of W
        m_wready = 1'b0;
        send(16, 1'b0);
        wait_wv();
        rst      = 1'b1;
        to_send  = 0;
        m_bvalid = 1'b0;
        b_pend   = 1'b0;
        b_clr    = 1'b0;
        wb       = 0;
        #1;
        chk("s6_awvalid", 64'(m_awvalid), 64'd0);
        chk("s6_wvalid", 64'(m_wvalid), 64'd0);
        chk("s6_bready", 64'(m_bready), 64'd0);
        chk("s6_wr_ptr", 64'(sts_wr_ptr), 64'd0);
        chk("s6_s_ready", 64'(s_ready), 64'd1);
        tick(1);
        rst      = 1'b0;
        m_wready = 1'b1;
        exp_w    = seq;
        tick(20);
        chk("s6_fifo_empty", 64'(aw_n), 64'd11);
        send(16, 1'b0);
        wait_b(11);
        chk("s6_awaddr", last_addr, 64'h1000);
        chk("s6_wr_ptr2", 64'(sts_wr_ptr), 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
